tmr_vote_reader: RTL and testbench



---
 rtl/tmr_vote_reader_pkg.sv | 21 ++
 rtl/tmr_vote_reader_if.sv | 29 ++
 rtl/tmr_vote_reader_sat_counter.sv | 28 ++
 rtl/tmr_vote_reader.sv | 184 ++++++++++++++++++
 tb/tb_tmr_vote_reader.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tmr_vote_reader_pkg.sv
// tmr_pkg: shared definitions for the triplicated-register vote reader.
//   state_t : reader FSM states
//   maj3    : single-bit 2-of-3 majority
//   NLANES  : number of redundant register copies
package tmr_pkg;

  localparam int NLANES = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VOTE  = 2'd1,
    SCRUB = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Bitwise callers loop over the word, so this stays width-agnostic.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (b & c) | (a & c);
  endfunction

endpackage

// File: rtl/tmr_vote_reader_if.sv
// tmr_vote_reader_if: read-side handshake bundle of the vote reader.
//   in_valid/in_ready : upstream offers the three copies d0..d2
//   out_valid/out_ready : downstream takes the voted word q
// master drives the copies and out_ready; slave (the reader) drives
// in_ready, out_valid and q.
interface tmr_vote_reader_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;

  modport master (
    output in_valid, d0, d1, d2, out_ready,
    input  in_ready, out_valid, q
  );

  modport slave (
    input  in_valid, d0, d1, d2, out_ready,
    output in_ready, out_valid, q
  );

endinterface

// File: rtl/tmr_vote_reader_sat_counter.sv
// sat_counter: per-lane disagreement counter.
//   clk, rst_n : clock, async active-low reset
//   inc        : count one event (ignored once at all-ones)
//   clr        : synchronous clear, wins over inc
//   cnt        : current count
module sat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tmr_vote_reader.sv
// tmr_vote_reader: captures three redundant copies of a result register,
// forms the bitwise 2-of-3 majority, hands it downstream over valid/ready
// and asks for a write-back of the copies that disagreed.
//
// Ports
//   clk, rst_n         : clock, async active-low reset
//   bus (slave)        : in_valid/in_ready/d0..d2 in, out_valid/out_ready/q out
//   scrub_req          : one-cycle write-back request
//   scrub_data         : voted word to write back (0 when no request)
//   scrub_mask         : lanes to rewrite, bit i = lane i (0 when no request)
//   err_lane           : sticky per-lane disagreement flags
//   err_cnt0..2        : saturating per-lane disagreement counts
//   fatal              : sticky, a word arrived where no copy matched the vote
//   clear_err          : synchronous clear of err_lane, err_cnt*, fatal
//
// state | meaning
// IDLE  | in_ready high, waiting for a word to capture
// VOTE  | majority and mismatch evaluated, error registers updated
// SCRUB | scrub_req pulse with voted word and mismatch mask
// OUT   | out_valid high with q stable until out_ready
module tmr_vote_reader
  import tmr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  tmr_vote_reader_if.slave    bus,
  output logic                scrub_req,
  output logic [WIDTH-1:0]    scrub_data,
  output logic [NLANES-1:0]   scrub_mask,
  output logic [NLANES-1:0]   err_lane,
  output logic [CNT_W-1:0]    err_cnt0,
  output logic [CNT_W-1:0]    err_cnt1,
  output logic [CNT_W-1:0]    err_cnt2,
  output logic                fatal,
  input  logic                clear_err
);

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0]  c0, c1, c2;
  logic [WIDTH-1:0]  vote;
  logic [NLANES-1:0] mis;
  logic              no_match;
  logic              in_vote;
  logic              capture;

  logic              in_ready_r;
  logic              out_valid_r;
  logic [WIDTH-1:0]  q_r;

  logic              in_ready_d;
  logic              out_valid_d;
  logic              scrub_req_d;
  logic [WIDTH-1:0]  scrub_data_d;
  logic [NLANES-1:0] scrub_mask_d;
  logic [WIDTH-1:0]  q_d;

  // in_ready is a flop that is 0 in reset, so the capture qualifier uses
  // the flop too: nothing is taken in the first cycle after reset release.
  assign capture = (state == IDLE) && bus.in_valid && in_ready_r;
  assign in_vote = (state == VOTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c0 <= '0;
      c1 <= '0;
      c2 <= '0;
    end else if (capture) begin
      c0 <= bus.d0;
      c1 <= bus.d1;
      c2 <= bus.d2;
    end
  end

  always_comb begin
    vote = '0;
    for (int i = 0; i < WIDTH; i++) begin
      vote[i] = maj3(c0[i], c1[i], c2[i]);
    end
  end

  assign mis      = {(c2 != vote), (c1 != vote), (c0 != vote)};
  // Every lane differs from the vote: the vote itself is untrustworthy.
  assign no_match = &mis;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (capture) next_state = VOTE;
      VOTE:    next_state = ((mis != '0) && !no_match) ? SCRUB : OUT;
      SCRUB:   next_state = OUT;
      OUT:     if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: values for the output flops, decoded from the state we
  // are about to enter so every handshake/scrub output is a plain flop.
  always_comb begin
    in_ready_d   = (next_state == IDLE);
    out_valid_d  = (next_state == OUT);
    scrub_req_d  = (next_state == SCRUB);
    scrub_data_d = scrub_req_d ? vote : '0;
    scrub_mask_d = scrub_req_d ? mis  : '0;
    q_d          = in_vote ? vote : q_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      scrub_req   <= 1'b0;
      scrub_data  <= '0;
      scrub_mask  <= '0;
      q_r         <= '0;
    end else begin
      in_ready_r  <= in_ready_d;
      out_valid_r <= out_valid_d;
      scrub_req   <= scrub_req_d;
      scrub_data  <= scrub_data_d;
      scrub_mask  <= scrub_mask_d;
      q_r         <= q_d;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.q         = q_r;

  // Error bookkeeping; clear_err wins over a same-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_lane <= '0;
      fatal    <= 1'b0;
    end else if (clear_err) begin
      err_lane <= '0;
      fatal    <= 1'b0;
    end else if (in_vote) begin
      err_lane <= err_lane | mis;
      if (no_match) begin
        fatal <= 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt0 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (in_vote & mis[0]),
    .clr   (clear_err),
    .cnt   (err_cnt0)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt1 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (in_vote & mis[1]),
    .clr   (clear_err),
    .cnt   (err_cnt1)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt2 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (in_vote & mis[2]),
    .clr   (clear_err),
    .cnt   (err_cnt2)
  );

endmodule

// File: tb/tb_tmr_vote_reader.sv
// tb_tmr_vote_reader: table vectors, hand-written corner sequences and
// randomized words checked against a counting-based reference model.
module tb_tmr_vote_reader;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             clear_err;
  logic             scrub_req;
  logic [WIDTH-1:0] scrub_data;
  logic [2:0]       scrub_mask;
  logic [2:0]       err_lane;
  logic [CNT_W-1:0] err_cnt0, err_cnt1, err_cnt2;
  logic             fatal;

  tmr_vote_reader_if #(.WIDTH(WIDTH)) bus ();

  tmr_vote_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .scrub_req  (scrub_req),
    .scrub_data (scrub_data),
    .scrub_mask (scrub_mask),
    .err_lane   (err_lane),
    .err_cnt0   (err_cnt0),
    .err_cnt1   (err_cnt1),
    .err_cnt2   (err_cnt2),
    .fatal      (fatal),
    .clear_err  (clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model of the error registers
  int         m_cnt [3];
  logic [2:0] m_lane;
  logic       m_fatal;

  typedef struct {
    logic [7:0] d0, d1, d2;
    logic [7:0] exp_q;
    logic [2:0] exp_mask;
    logic       exp_scrub;
    logic       exp_fatal;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // majority by counting ones per bit position
  function automatic logic [7:0] ref_vote(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      int ones;
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      r[i] = (ones >= 2);
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_lane  = 3'b000;
    m_fatal = 1'b0;
  endtask

  task automatic model_update(input logic [2:0] mis, input bit nomatch, input bit clr);
    if (clr) begin
      model_clear();
    end else begin
      for (int i = 0; i < 3; i++)
        if (mis[i] && m_cnt[i] < CNT_MAX) m_cnt[i] = m_cnt[i] + 1;
      m_lane = m_lane | mis;
      if (nomatch) m_fatal = 1'b1;
    end
  endtask

  task automatic chk_errs(input string tag);
    chk({tag, ".err_cnt0"}, 32'(err_cnt0), 32'(m_cnt[0]));
    chk({tag, ".err_cnt1"}, 32'(err_cnt1), 32'(m_cnt[1]));
    chk({tag, ".err_cnt2"}, 32'(err_cnt2), 32'(m_cnt[2]));
    chk({tag, ".err_lane"}, 32'(err_lane), 32'(m_lane));
    chk({tag, ".fatal"},    32'(fatal),    32'(m_fatal));
  endtask

  task automatic clear_pulse();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    model_clear();
    chk_errs("idle_clear");
  endtask

  // One full transaction, entered and left at a negedge. Expectations come
  // from the reference model; observed values are returned for table checks.
  task automatic send_word(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input int hold, input bit clr_in_vote,
                           output logic [7:0] gq, output logic [2:0] gmask,
                           output logic gscrub, output logic gfatal);
    logic [7:0] v;
    logic [2:0] mis;
    bit         nomatch, exp_scrub;
    int         n;
    v         = ref_vote(a, b, c);
    mis       = {c != v, b != v, a != v};
    nomatch   = (a != v) && (b != v) && (c != v);
    exp_scrub = (mis != 3'b000) && !nomatch;

    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("in_ready_wait", 32'(bus.in_ready), 32'd1);

    bus.in_valid = 1'b1;
    bus.d0 = a;
    bus.d1 = b;
    bus.d2 = c;
    @(negedge clk);                       // VOTE cycle
    bus.in_valid = 1'b0;
    chk("vote.out_valid", 32'(bus.out_valid), 32'd0);
    chk("vote.scrub_req", 32'(scrub_req), 32'd0);
    chk("vote.in_ready",  32'(bus.in_ready), 32'd0);
    if (clr_in_vote) clear_err = 1'b1;
    @(negedge clk);                       // cycle N+2
    clear_err = 1'b0;
    model_update(mis, nomatch, clr_in_vote);
    gscrub = scrub_req;
    gmask  = scrub_mask;
    gfatal = fatal;
    chk("n2.scrub_req",  32'(scrub_req),  32'(exp_scrub));
    chk("n2.scrub_mask", 32'(scrub_mask), exp_scrub ? 32'(mis) : 32'd0);
    chk("n2.scrub_data", 32'(scrub_data), exp_scrub ? 32'(v) : 32'd0);
    chk_errs("n2");
    if (exp_scrub) begin
      chk("scrub.out_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);                     // cycle N+3
      chk("n3.scrub_req",  32'(scrub_req),  32'd0);
      chk("n3.scrub_mask", 32'(scrub_mask), 32'd0);
    end
    chk("out.out_valid", 32'(bus.out_valid), 32'd1);
    chk("out.q",         32'(bus.q),         32'(v));
    chk("out.in_ready",  32'(bus.in_ready),  32'd0);
    gq = bus.q;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;                // must be ignored while busy
      bus.d0 = 8'($urandom);
      @(negedge clk);
      chk("hold.out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold.q",         32'(bus.q),         32'(v));
      chk("hold.in_ready",  32'(bus.in_ready),  32'd0);
      chk("hold.scrub_req", 32'(scrub_req),     32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("done.out_valid", 32'(bus.out_valid), 32'd0);
    chk("done.in_ready",  32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] gq, v, fm, a, b, c;
    logic [2:0] gmask;
    logic       gscrub, gfatal;
    int         pat, lane;

    vecs[0] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 3'b000, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 8'hA5, 8'h25, 8'hA5, 3'b100, 1'b1, 1'b0};
    vecs[2] = '{8'h0F, 8'hF0, 8'h3C, 8'h3C, 3'b011, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 3'b100, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 8'h80, 8'h80, 8'h80, 3'b001, 1'b1, 1'b0};
    vecs[5] = '{8'h01, 8'h02, 8'h04, 8'h00, 3'b000, 1'b0, 1'b1};

    rst_n         = 1'b0;
    clear_err     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.d0 = '0;
    bus.d1 = '0;
    bus.d2 = '0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    chk("rst.in_ready",   32'(bus.in_ready),  32'd0);
    chk("rst.out_valid",  32'(bus.out_valid), 32'd0);
    chk("rst.q",          32'(bus.q),         32'd0);
    chk("rst.scrub_req",  32'(scrub_req),     32'd0);
    chk_errs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst.in_ready", 32'(bus.in_ready), 32'd1);

    // table vectors; the clean word also checks that counters stay at 0
    for (int i = 0; i < 6; i++) begin
      send_word(vecs[i].d0, vecs[i].d1, vecs[i].d2, (i == 1) ? 5 : 0, 1'b0,
                gq, gmask, gscrub, gfatal);
      chk($sformatf("vec%0d.q", i),     32'(gq),     32'(vecs[i].exp_q));
      chk($sformatf("vec%0d.mask", i),  32'(gmask),  32'(vecs[i].exp_mask));
      chk($sformatf("vec%0d.scrub", i), 32'(gscrub), 32'(vecs[i].exp_scrub));
      chk($sformatf("vec%0d.fatal", i), 32'(gfatal), 32'(vecs[i].exp_fatal));
    end
    chk("vec.err_cnt2_after_a5_25", 32'(err_cnt2), 32'(m_cnt[2]));

    // saturation on lane 0, then clear colliding with an increment
    clear_pulse();
    for (int i = 0; i < 20; i++) begin
      v = 8'h5A + 8'(i);
      send_word(v ^ 8'h10, v, v, 0, 1'b0, gq, gmask, gscrub, gfatal);
    end
    chk("sat.err_cnt0", 32'(err_cnt0), 32'd15);
    send_word(8'h33 ^ 8'h01, 8'h33, 8'h33, 0, 1'b1, gq, gmask, gscrub, gfatal);
    chk("clr_vs_inc.err_cnt0", 32'(err_cnt0), 32'd0);
    chk("clr_vs_inc.err_lane", 32'(err_lane), 32'd0);

    // reset during SCRUB drops the word
    send_word(8'h11, 8'h11, 8'h11, 0, 1'b0, gq, gmask, gscrub, gfatal);
    bus.in_valid = 1'b1;
    bus.d0 = 8'hA5;
    bus.d1 = 8'hA5;
    bus.d2 = 8'h25;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid.scrub_before", 32'(scrub_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_mid.scrub_req",  32'(scrub_req),     32'd0);
    chk("rst_mid.scrub_data", 32'(scrub_data),    32'd0);
    chk("rst_mid.scrub_mask", 32'(scrub_mask),    32'd0);
    chk("rst_mid.out_valid",  32'(bus.out_valid), 32'd0);
    chk("rst_mid.in_ready",   32'(bus.in_ready),  32'd0);
    chk("rst_mid.q",          32'(bus.q),         32'd0);
    chk_errs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel.in_ready",  32'(bus.in_ready),  32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rel.out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_rel.scrub_req", 32'(scrub_req),     32'd0);
    end

    // randomized words
    for (int i = 0; i < 40; i++) begin
      v   = 8'($urandom);
      fm  = 8'($urandom_range(255, 1));
      pat = $urandom_range(4, 0);
      a = v; b = v; c = v;
      case (pat)
        1: begin
          lane = $urandom_range(2, 0);
          if (lane == 0) a = v ^ fm;
          else if (lane == 1) b = v ^ fm;
          else c = v ^ fm;
        end
        2: begin
          a = 8'($urandom);
          b = 8'($urandom);
          c = 8'($urandom);
        end
        3: begin
          a = v ^ fm;
          c = v ^ 8'($urandom);
        end
        4: c = 8'($urandom);
        default: ;
      endcase
      if ($urandom_range(7, 0) == 0) clear_pulse();
      send_word(a, b, c, $urandom_range(3, 0), ($urandom_range(9, 0) == 0),
                gq, gmask, gscrub, gfatal);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
